// File: rtl/shf_barrel_pipe.sv
// rtl/shf_barrel_pipe.sv - pipelined bidirectional barrel shifter with sticky and valid/ready backpressure
// Optional rotate datapath: define SHF_ROTATE_EN.
module shf_barrel_pipe #(
  parameter int SIZE_DATA  = 32,
  parameter int SIZE_SHIFT = 5,
  parameter int REG_EVERY  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [SIZE_DATA-1:0]  i_data,
  input  logic [SIZE_SHIFT-1:0] i_shift_number,
  input  logic                  i_dir,
  input  logic                  i_arith,
  input  logic                  i_rot,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [SIZE_DATA-1:0]  o_data,
  output logic                  o_sticky
);

  localparam int L = (SIZE_SHIFT + REG_EVERY - 1) / REG_EVERY;

  if ((1 << (SIZE_SHIFT - 1)) >= SIZE_DATA) begin : g_bad_shift
    $error("shf_barrel_pipe: largest stage shift must be smaller than SIZE_DATA");
  end
  if (REG_EVERY < 1 || REG_EVERY > SIZE_SHIFT) begin : g_bad_reg_every
    $error("shf_barrel_pipe: REG_EVERY must be within 1..SIZE_SHIFT");
  end

  logic rot_req;
`ifdef SHF_ROTATE_EN
  assign rot_req = i_rot;
`else
  logic unused_rot;
  assign rot_req    = 1'b0;
  assign unused_rot = i_rot;
`endif

  // load[g]: register group g may capture this cycle (empty, or its beat moves on)
  logic [L-1:0] load;
  assign o_ready = load[0];

  genvar g;
  for (g = 0; g < L; g++) begin : g_grp
    localparam int LO = g * REG_EVERY;
    localparam int HI = ((g + 1) * REG_EVERY < SIZE_SHIFT) ? (g + 1) * REG_EVERY : SIZE_SHIFT;

    logic [SIZE_DATA-1:0]  r_data;
    logic [SIZE_SHIFT-1:0] r_amt;
    logic                  r_valid;
    logic                  r_sticky;
    logic                  r_dir;
    logic                  r_fill;
    logic                  r_rot;

    logic [SIZE_DATA-1:0]  in_data;
    logic [SIZE_SHIFT-1:0] in_amt;
    logic                  in_valid;
    logic                  in_sticky;
    logic                  in_dir;
    logic                  in_fill;
    logic                  in_rot;

    logic [SIZE_DATA-1:0]  nx_data;
    logic                  nx_sticky;

    if (g == 0) begin : g_src
      assign in_data   = i_data;
      assign in_amt    = i_shift_number;
      assign in_valid  = i_valid;
      assign in_sticky = 1'b0;
      assign in_dir    = i_dir;
      assign in_fill   = i_dir & i_arith & i_data[SIZE_DATA-1];
      assign in_rot    = rot_req;
    end else begin : g_src
      assign in_data   = g_grp[g-1].r_data;
      assign in_amt    = g_grp[g-1].r_amt;
      assign in_valid  = g_grp[g-1].r_valid;
      assign in_sticky = g_grp[g-1].r_sticky;
      assign in_dir    = g_grp[g-1].r_dir;
      assign in_fill   = g_grp[g-1].r_fill;
      assign in_rot    = g_grp[g-1].r_rot;
    end

    if (g == L - 1) begin : g_load
      assign load[g] = ~r_valid | i_ready;
    end else begin : g_load
      assign load[g] = ~r_valid | load[g+1];
    end

    // Mux stages LO..HI-1; each stage shift is below SIZE_DATA, so over-range
    // totals saturate to all-fill naturally and sticky gathers every lost bit.
    always_comb begin
      nx_data   = in_data;
      nx_sticky = in_sticky;
      for (int j = LO; j < HI; j++) begin
        if (in_amt[j]) begin
`ifdef SHF_ROTATE_EN
          if (in_rot) begin
            if (in_dir)
              nx_data = (nx_data >> (1 << j)) | (nx_data << (SIZE_DATA - (1 << j)));
            else
              nx_data = (nx_data << (1 << j)) | (nx_data >> (SIZE_DATA - (1 << j)));
          end else
`endif
          if (in_dir) begin
            nx_sticky = nx_sticky | (|(nx_data & ~({SIZE_DATA{1'b1}} << (1 << j))));
            nx_data   = ({SIZE_DATA{in_fill}} << (SIZE_DATA - (1 << j))) | (nx_data >> (1 << j));
          end else begin
            nx_data = nx_data << (1 << j);
          end
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_valid  <= 1'b0;
        r_data   <= '0;
        r_amt    <= '0;
        r_sticky <= 1'b0;
        r_dir    <= 1'b0;
        r_fill   <= 1'b0;
        r_rot    <= 1'b0;
      end else if (load[g]) begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_data   <= nx_data;
          r_amt    <= in_amt;
          r_sticky <= nx_sticky;
          r_dir    <= in_dir;
          r_fill   <= in_fill;
          r_rot    <= in_rot;
        end
      end
    end

    // Control bits already consumed upstream, or past the last mux stage.
    logic unused_ctl;
    assign unused_ctl = ^{r_amt, r_dir, r_fill, r_rot};
  end

  assign o_valid  = g_grp[L-1].r_valid;
  assign o_data   = g_grp[L-1].r_data;
  assign o_sticky = g_grp[L-1].r_sticky;

endmodule
